dcd_axil_slave_mem: RTL and testbench

AXI4-Lite slave responder with a small word-addressed memory. It is the target end of the dcd M00_AXI master's write-then-read-back test, and replaces the slave VIP in hardware builds. It accepts independent AW and W channels, applies WSTRB byte lanes, and returns read data. Out-of-window accesses get SLVERR. Status counters report transaction and error totals.

---
 rtl/dcd_axil_slave_mem_if.sv | 60 ++++++
 rtl/dcd_axil_slave_mem.sv | 229 ++++++++++++++++++++++
 tb/tb_dcd_axil_slave_mem.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcd_axil_slave_mem_if.sv
// ---------------------------------------------------------------------------
// dcd_axil_slave_mem_if
// AXI4-Lite bus bundle between the dcd M00_AXI master and the slave memory.
//   AW channel : S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_AWREADY
//   W  channel : S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_WREADY
//   B  channel : S_AXI_BRESP, S_AXI_BVALID, S_AXI_BREADY
//   AR channel : S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_ARREADY
//   R  channel : S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, S_AXI_RREADY
// Modports: master (drives requests), slave (drives responses/readies).
// ---------------------------------------------------------------------------
interface dcd_axil_slave_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();
  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic [2:0]          S_AXI_AWPROT;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic [2:0]          S_AXI_ARPROT;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );
endinterface

// File: rtl/dcd_axil_slave_mem.sv
// ---------------------------------------------------------------------------
// dcd_axil_slave_mem
// AXI4-Lite slave responder backed by a small word-addressed memory.
// Independent AW/W capture, WSTRB byte-lane writes, 1-cycle read latency,
// SLVERR for accesses outside [BASE_ADDR, BASE_ADDR + 4*MEM_DEPTH).
// Ports:
//   ACLK       in   clock, rising edge
//   ARESETN    in   synchronous active-low reset (also clears the memory)
//   s_axi      slave modport of dcd_axil_slave_mem_if (AW/W/B/AR/R)
//   WR_COUNT   out  completed write responses, saturating
//   RD_COUNT   out  completed read responses, saturating
//   ERR_COUNT  out  SLVERR responses on either channel, saturating
// ---------------------------------------------------------------------------
module dcd_axil_slave_mem #(
  parameter int                            C_S_AXI_DATA_WIDTH = 32,
  parameter int                            C_S_AXI_ADDR_WIDTH = 32,
  parameter int                            MEM_DEPTH          = 16,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = 32'h4000_0000
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  dcd_axil_slave_mem_if.slave         s_axi,
  output logic [15:0]                 WR_COUNT,
  output logic [15:0]                 RD_COUNT,
  output logic [7:0]                  ERR_COUNT
);

  localparam int AW     = C_S_AXI_ADDR_WIDTH;
  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int SW     = DW / 8;
  localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // In range when at/above the base and the word offset fits the memory.
  // MEM_DEPTH is a power of two, so "idx < MEM_DEPTH" is "upper offset bits zero".
  function automatic logic addr_in_range(input logic [AW-1:0] addr);
    logic [AW-1:0] off;
    off = addr - BASE_ADDR;
    return (addr >= BASE_ADDR) && (off[AW-1:2+IDX_W] == {(AW-2-IDX_W){1'b0}});
  endfunction

  // Word index; byte offset bits [1:0] are ignored.
  function automatic logic [IDX_W-1:0] addr_index(input logic [AW-1:0] addr);
    logic [AW-1:0] off;
    off = addr - BASE_ADDR;
    return off[2 +: IDX_W];
  endfunction

  logic [DW-1:0]    r_mem [MEM_DEPTH];

  logic             r_aw_held;
  logic [AW-1:0]    r_awaddr;
  logic             r_w_held;
  logic [DW-1:0]    r_wdata;
  logic [SW-1:0]    r_wstrb;
  logic             r_awready;
  logic             r_wready;
  logic             r_bvalid;
  logic [1:0]       r_bresp;
  logic             r_arready;
  logic             r_rvalid;
  logic [DW-1:0]    r_rdata;
  logic [1:0]       r_rresp;
  logic [15:0]      r_wr_count;
  logic [15:0]      r_rd_count;
  logic [7:0]       r_err_count;

  logic             w_aw_hs;
  logic             w_w_hs;
  logic             w_b_hs;
  logic             w_ar_hs;
  logic             w_r_hs;
  logic             w_commit;
  logic [AW-1:0]    w_wr_addr;
  logic [DW-1:0]    w_wr_data;
  logic [SW-1:0]    w_wr_strb;
  logic             w_wr_in;
  logic [IDX_W-1:0] w_wr_idx;
  logic             w_rd_in;
  logic [IDX_W-1:0] w_rd_idx;
  logic             w_aw_held_nx;
  logic             w_w_held_nx;
  logic             w_bvalid_nx;
  logic             w_rvalid_nx;
  logic [1:0]       w_err_add;
  logic [8:0]       w_err_sum;
  logic [7:0]       w_err_nx;
  logic [15:0]      w_wr_nx;
  logic [15:0]      w_rd_nx;
  logic             w_unused;

  assign w_unused = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};

  // Handshakes, write commit, next-state of hold/valid flags and counters.
  always_comb begin
    w_aw_hs   = s_axi.S_AXI_AWVALID && r_awready;
    w_w_hs    = s_axi.S_AXI_WVALID && r_wready;
    w_b_hs    = r_bvalid && s_axi.S_AXI_BREADY;
    w_ar_hs   = s_axi.S_AXI_ARVALID && r_arready;
    w_r_hs    = r_rvalid && s_axi.S_AXI_RREADY;
    // A half arriving this edge is used directly, so no extra cycle is spent.
    w_wr_addr = w_aw_hs ? s_axi.S_AXI_AWADDR : r_awaddr;
    w_wr_data = w_w_hs ? s_axi.S_AXI_WDATA : r_wdata;
    w_wr_strb = w_w_hs ? s_axi.S_AXI_WSTRB : r_wstrb;
    w_commit  = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
    w_wr_in   = addr_in_range(w_wr_addr);
    w_wr_idx  = addr_index(w_wr_addr);
    w_rd_in   = addr_in_range(s_axi.S_AXI_ARADDR);
    w_rd_idx  = addr_index(s_axi.S_AXI_ARADDR);

    if (w_commit) begin
      w_aw_held_nx = 1'b0;
      w_w_held_nx  = 1'b0;
    end else begin
      w_aw_held_nx = r_aw_held || w_aw_hs;
      w_w_held_nx  = r_w_held || w_w_hs;
    end

    if (w_commit) begin
      w_bvalid_nx = 1'b1;
    end else if (w_b_hs) begin
      w_bvalid_nx = 1'b0;
    end else begin
      w_bvalid_nx = r_bvalid;
    end

    if (w_ar_hs) begin
      w_rvalid_nx = 1'b1;
    end else if (w_r_hs) begin
      w_rvalid_nx = 1'b0;
    end else begin
      w_rvalid_nx = r_rvalid;
    end

    if (w_b_hs && (r_wr_count != 16'hFFFF)) begin
      w_wr_nx = r_wr_count + 16'd1;
    end else begin
      w_wr_nx = r_wr_count;
    end

    if (w_r_hs && (r_rd_count != 16'hFFFF)) begin
      w_rd_nx = r_rd_count + 16'd1;
    end else begin
      w_rd_nx = r_rd_count;
    end

    // Both channels can report SLVERR on the same edge: add 0..2, saturate.
    w_err_add = {1'b0, (w_b_hs && (r_bresp == RESP_SLVERR))}
              + {1'b0, (w_r_hs && (r_rresp == RESP_SLVERR))};
    w_err_sum = {1'b0, r_err_count} + {7'd0, w_err_add};
    if (w_err_sum[8]) begin
      w_err_nx = 8'hFF;
    end else begin
      w_err_nx = w_err_sum[7:0];
    end
  end

  // State, memory and registered outputs; readies derive from next-state flags.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_aw_held   <= 1'b0;
      r_awaddr    <= {AW{1'b0}};
      r_w_held    <= 1'b0;
      r_wdata     <= {DW{1'b0}};
      r_wstrb     <= {SW{1'b0}};
      r_awready   <= 1'b0;
      r_wready    <= 1'b0;
      r_bvalid    <= 1'b0;
      r_bresp     <= RESP_OKAY;
      r_arready   <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rdata     <= {DW{1'b0}};
      r_rresp     <= RESP_OKAY;
      r_wr_count  <= 16'd0;
      r_rd_count  <= 16'd0;
      r_err_count <= 8'd0;
      for (int i = 0; i < MEM_DEPTH; i++) begin
        r_mem[i] <= {DW{1'b0}};
      end
    end else begin
      r_aw_held   <= w_aw_held_nx;
      r_w_held    <= w_w_held_nx;
      r_bvalid    <= w_bvalid_nx;
      r_rvalid    <= w_rvalid_nx;
      r_awready   <= !w_aw_held_nx && !w_bvalid_nx;
      r_wready    <= !w_w_held_nx && !w_bvalid_nx;
      r_arready   <= !w_rvalid_nx;
      r_wr_count  <= w_wr_nx;
      r_rd_count  <= w_rd_nx;
      r_err_count <= w_err_nx;
      if (w_aw_hs) begin
        r_awaddr <= s_axi.S_AXI_AWADDR;
      end
      if (w_w_hs) begin
        r_wdata <= s_axi.S_AXI_WDATA;
        r_wstrb <= s_axi.S_AXI_WSTRB;
      end
      if (w_commit) begin
        r_bresp <= w_wr_in ? RESP_OKAY : RESP_SLVERR;
        if (w_wr_in) begin
          for (int b = 0; b < SW; b++) begin
            if (w_wr_strb[b]) begin
              r_mem[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
            end
          end
        end
      end
      // Same-edge write to the same word is not bypassed: old data is returned.
      if (w_ar_hs) begin
        r_rdata <= w_rd_in ? r_mem[w_rd_idx] : {DW{1'b0}};
        r_rresp <= w_rd_in ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign s_axi.S_AXI_AWREADY = r_awready;
  assign s_axi.S_AXI_WREADY  = r_wready;
  assign s_axi.S_AXI_BVALID  = r_bvalid;
  assign s_axi.S_AXI_BRESP   = r_bresp;
  assign s_axi.S_AXI_ARREADY = r_arready;
  assign s_axi.S_AXI_RVALID  = r_rvalid;
  assign s_axi.S_AXI_RDATA   = r_rdata;
  assign s_axi.S_AXI_RRESP   = r_rresp;
  assign WR_COUNT            = r_wr_count;
  assign RD_COUNT            = r_rd_count;
  assign ERR_COUNT           = r_err_count;

endmodule

// File: tb/tb_dcd_axil_slave_mem.sv
// ---------------------------------------------------------------------------
// tb_dcd_axil_slave_mem
// Directed bench: a table of single transactions with hand-computed results,
// followed by hand-written sequences for ordering, backpressure, dual error,
// counter saturation and reset during outstanding responses.
// ---------------------------------------------------------------------------
module tb_dcd_axil_slave_mem;

  logic        clk;
  logic        rst_n;
  logic [15:0] wr_count;
  logic [15:0] rd_count;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_errors = 0;
  int exp_wr   = 0;
  int exp_rd   = 0;
  int exp_err  = 0;

  dcd_axil_slave_mem_if #(.DATA_W(32), .ADDR_W(32)) axi ();

  dcd_axil_slave_mem dut (
    .ACLK      (clk),
    .ARESETN   (rst_n),
    .s_axi     (axi.slave),
    .WR_COUNT  (wr_count),
    .RD_COUNT  (rd_count),
    .ERR_COUNT (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;   // write data, or expected read data
    logic [3:0]  strb;
    logic [1:0]  resp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_wr_count"},  {16'd0, wr_count}, exp_wr);
    check({tag, "_rd_count"},  {16'd0, rd_count}, exp_rd);
    check({tag, "_err_count"}, {24'd0, err_count}, exp_err);
  endtask

  task automatic count_err(input logic [1:0] resp);
    if (resp == 2'b10) begin
      exp_err = (exp_err + 1 > 255) ? 255 : exp_err + 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] exp_resp);
    bit aw_d, w_d, aw_f, w_f;
    int n;
    axi.S_AXI_AWADDR  = addr;
    axi.S_AXI_WDATA   = data;
    axi.S_AXI_WSTRB   = strb;
    axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_WVALID  = 1'b1;
    axi.S_AXI_BREADY  = 1'b1;
    aw_d = 1'b0; w_d = 1'b0; n = 0;
    while (!(aw_d && w_d) && n < 20) begin
      aw_f = axi.S_AXI_AWVALID && axi.S_AXI_AWREADY;
      w_f  = axi.S_AXI_WVALID && axi.S_AXI_WREADY;
      tick();
      n++;
      if (aw_f) begin aw_d = 1'b1; axi.S_AXI_AWVALID = 1'b0; end
      if (w_f)  begin w_d  = 1'b1; axi.S_AXI_WVALID  = 1'b0; end
    end
    check("wr_handshake_done", {31'd0, aw_d && w_d}, 32'd1);
    check("wr_bvalid_latency", {31'd0, axi.S_AXI_BVALID}, 32'd1);
    check("wr_bresp", {30'd0, axi.S_AXI_BRESP}, {30'd0, exp_resp});
    tick();
    axi.S_AXI_BREADY = 1'b0;
    exp_wr++;
    count_err(exp_resp);
    check("wr_bvalid_drop", {31'd0, axi.S_AXI_BVALID}, 32'd0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input bit throttle);
    bit ar_f, r_f, done;
    int n;
    axi.S_AXI_ARADDR  = addr;
    axi.S_AXI_ARVALID = 1'b1;
    axi.S_AXI_RREADY  = 1'b0;
    done = 1'b0; n = 0;
    while (!done && n < 20) begin
      ar_f = axi.S_AXI_ARVALID && axi.S_AXI_ARREADY;
      tick();
      n++;
      if (ar_f) begin done = 1'b1; axi.S_AXI_ARVALID = 1'b0; end
    end
    check("rd_handshake_done", {31'd0, done}, 32'd1);
    check("rd_rvalid_latency", {31'd0, axi.S_AXI_RVALID}, 32'd1);
    check("rd_rdata", axi.S_AXI_RDATA, exp_data);
    check("rd_rresp", {30'd0, axi.S_AXI_RRESP}, {30'd0, exp_resp});
    done = 1'b0; n = 0;
    while (!done && n < 40) begin
      axi.S_AXI_RREADY = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      r_f = axi.S_AXI_RVALID && axi.S_AXI_RREADY;
      if (!r_f) begin
        check("rd_rdata_stable", axi.S_AXI_RDATA, exp_data);
      end
      tick();
      n++;
      if (r_f) done = 1'b1;
    end
    axi.S_AXI_RREADY = 1'b0;
    check("rd_r_handshake_done", {31'd0, done}, 32'd1);
    exp_rd++;
    count_err(exp_resp);
    check("rd_rvalid_drop", {31'd0, axi.S_AXI_RVALID}, 32'd0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_wr = 0; exp_rd = 0; exp_err = 0;
  endtask

  vec_t vecs[12];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1'b1, 32'h4000_0004, 32'hDEAD_BEEF, 4'hF, 2'b00};
    vecs[1]  = '{1'b0, 32'h4000_0004, 32'hDEAD_BEEF, 4'h0, 2'b00};
    vecs[2]  = '{1'b1, 32'h4000_0008, 32'h1122_3344, 4'hF, 2'b00};
    vecs[3]  = '{1'b1, 32'h4000_0008, 32'hAABB_CCDD, 4'h5, 2'b00};
    vecs[4]  = '{1'b0, 32'h4000_0008, 32'h11BB_33DD, 4'h0, 2'b00};
    vecs[5]  = '{1'b1, 32'h4000_0040, 32'h1234_5678, 4'hF, 2'b10};
    vecs[6]  = '{1'b1, 32'h3FFF_FFFC, 32'h8765_4321, 4'hF, 2'b10};
    vecs[7]  = '{1'b0, 32'h5000_0000, 32'h0000_0000, 4'h0, 2'b10};
    vecs[8]  = '{1'b0, 32'h4000_0000, 32'h0000_0000, 4'h0, 2'b00};
    vecs[9]  = '{1'b0, 32'h4000_003C, 32'h0000_0000, 4'h0, 2'b00};
    vecs[10] = '{1'b1, 32'h4000_000B, 32'hFFFF_FFFF, 4'h0, 2'b00};
    vecs[11] = '{1'b0, 32'h4000_000A, 32'h11BB_33DD, 4'h0, 2'b00};

    rst_n = 1'b0;
    axi.S_AXI_AWADDR = 32'd0; axi.S_AXI_AWPROT = 3'd0; axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WDATA = 32'd0;  axi.S_AXI_WSTRB = 4'd0;  axi.S_AXI_WVALID = 1'b0;
    axi.S_AXI_BREADY = 1'b0;
    axi.S_AXI_ARADDR = 32'd0; axi.S_AXI_ARPROT = 3'd0; axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_RREADY = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_awready", {31'd0, axi.S_AXI_AWREADY}, 32'd0);
    check("rst_wready",  {31'd0, axi.S_AXI_WREADY},  32'd0);
    check("rst_arready", {31'd0, axi.S_AXI_ARREADY}, 32'd0);
    check("rst_bvalid",  {31'd0, axi.S_AXI_BVALID},  32'd0);
    check("rst_rvalid",  {31'd0, axi.S_AXI_RVALID},  32'd0);
    check("rst_rdata",   axi.S_AXI_RDATA, 32'd0);
    check_counters("rst");
    rst_n = 1'b1;
    tick();
    check("post_rst_awready", {31'd0, axi.S_AXI_AWREADY}, 32'd1);
    check("post_rst_arready", {31'd0, axi.S_AXI_ARREADY}, 32'd1);

    // Table: basic write/read, strobes, out-of-window, address low bits
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp);
      end else begin
        do_read(vecs[i].addr, vecs[i].data, vecs[i].resp, 1'b0);
      end
      check_counters($sformatf("vec%0d", i));
    end

    // W three cycles ahead of AW, BREADY held low for 4 cycles
    axi.S_AXI_WDATA = 32'h0BAD_F00D; axi.S_AXI_WSTRB = 4'hF; axi.S_AXI_WVALID = 1'b1;
    axi.S_AXI_AWADDR = 32'h4000_000C; axi.S_AXI_BREADY = 1'b0;
    check("ord_wready_pre", {31'd0, axi.S_AXI_WREADY}, 32'd1);
    tick();
    axi.S_AXI_WVALID = 1'b0;
    check("ord_wready_after_w", {31'd0, axi.S_AXI_WREADY}, 32'd0);
    check("ord_awready_after_w", {31'd0, axi.S_AXI_AWREADY}, 32'd1);
    repeat (2) begin
      tick();
      check("ord_bvalid_wait", {31'd0, axi.S_AXI_BVALID}, 32'd0);
    end
    axi.S_AXI_AWVALID = 1'b1;
    tick();
    axi.S_AXI_AWVALID = 1'b0;
    check("ord_bvalid_rise", {31'd0, axi.S_AXI_BVALID}, 32'd1);
    for (int c = 0; c < 4; c++) begin
      check("ord_bvalid_hold", {31'd0, axi.S_AXI_BVALID}, 32'd1);
      check("ord_bresp_hold", {30'd0, axi.S_AXI_BRESP}, 32'd0);
      check("ord_awready_hold", {31'd0, axi.S_AXI_AWREADY}, 32'd0);
      check("ord_wready_hold", {31'd0, axi.S_AXI_WREADY}, 32'd0);
      tick();
    end
    axi.S_AXI_BREADY = 1'b1;
    tick();
    axi.S_AXI_BREADY = 1'b0;
    exp_wr++;
    check("ord_bvalid_fall", {31'd0, axi.S_AXI_BVALID}, 32'd0);
    check("ord_awready_back", {31'd0, axi.S_AXI_AWREADY}, 32'd1);
    check("ord_wready_back", {31'd0, axi.S_AXI_WREADY}, 32'd1);
    check_counters("ord");
    do_read(32'h4000_000C, 32'h0BAD_F00D, 2'b00, 1'b0);

    // Four writes then throttled readbacks from a fresh reset
    apply_reset();
    tick();
    for (int i = 0; i < 4; i++) do_write(32'h4000_0000 + 32'(4 * i), 32'(i) + 32'hA0, 4'hF, 2'b00);
    for (int i = 0; i < 4; i++) do_read(32'h4000_0000 + 32'(4 * i), 32'(i) + 32'hA0, 2'b00, 1'b1);
    check_counters("seq4");

    // Dual SLVERR completions on the same edge; run past ERR_COUNT saturation
    for (int k = 0; k < 130; k++) begin
      axi.S_AXI_AWADDR = 32'h6000_0000; axi.S_AXI_WSTRB = 4'hF;
      axi.S_AXI_ARADDR = 32'h0000_0010;
      axi.S_AXI_AWVALID = 1'b1; axi.S_AXI_WVALID = 1'b1; axi.S_AXI_ARVALID = 1'b1;
      tick();
      axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0; axi.S_AXI_ARVALID = 1'b0;
      axi.S_AXI_BREADY = 1'b1; axi.S_AXI_RREADY = 1'b1;
      tick();
      axi.S_AXI_BREADY = 1'b0; axi.S_AXI_RREADY = 1'b0;
      exp_wr++; exp_rd++;
      exp_err = (exp_err + 2 > 255) ? 255 : exp_err + 2;
      check("dual_err_count", {24'd0, err_count}, exp_err);
    end
    check_counters("dual");

    // Reset while both a B and an R response are pending
    axi.S_AXI_AWADDR = 32'h4000_0004; axi.S_AXI_WDATA = 32'hCAFE_0001; axi.S_AXI_WSTRB = 4'hF;
    axi.S_AXI_ARADDR = 32'h4000_0000;
    axi.S_AXI_AWVALID = 1'b1; axi.S_AXI_WVALID = 1'b1; axi.S_AXI_ARVALID = 1'b1;
    tick();
    axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0; axi.S_AXI_ARVALID = 1'b0;
    check("prerst_bvalid", {31'd0, axi.S_AXI_BVALID}, 32'd1);
    check("prerst_rvalid", {31'd0, axi.S_AXI_RVALID}, 32'd1);
    check("prerst_rdata", axi.S_AXI_RDATA, 32'h0000_00A0);
    apply_reset();
    check("midrst_bvalid",  {31'd0, axi.S_AXI_BVALID},  32'd0);
    check("midrst_rvalid",  {31'd0, axi.S_AXI_RVALID},  32'd0);
    check("midrst_awready", {31'd0, axi.S_AXI_AWREADY}, 32'd0);
    check("midrst_wready",  {31'd0, axi.S_AXI_WREADY},  32'd0);
    check("midrst_arready", {31'd0, axi.S_AXI_ARREADY}, 32'd0);
    check_counters("midrst");
    tick();
    do_read(32'h4000_0004, 32'h0000_0000, 2'b00, 1'b0);
    do_read(32'h4000_0000, 32'h0000_0000, 2'b00, 1'b0);
    check_counters("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
